oflow_calc_iou_seq: RTL and testbench

Parametrised, handshaked successor to the single-pair IOU calculator in the oflow tracking path. It computes the fixed-point IOU, or the IOU distance (1 - IOU), between a frame-k bbox and a history bbox. Widths, fraction precision and mode are generic, and a tag passes through with each result. A sequential restoring divider replaces the combinational divide. The block sits between feature extraction and the cost-matrix/matching logic, one instance per comparison lane.

---
 rtl/oflow_calc_iou_pkg.sv | 28 ++
 rtl/oflow_seq_divider.sv | 56 +++++
 rtl/oflow_calc_iou_seq.sv | 174 +++++++++++++++++
 tb/tb_oflow_calc_iou_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/oflow_calc_iou_pkg.sv
// Shared types and constants for the sequential IOU calculator.
// Boxes pack as {X_TL, Y_TL, X_BR, Y_BR} with X_TL in the MSBs.
package oflow_calc_iou_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COORD,
    AREA,
    DIV,
    DONE
  } state_e;

  // Field index inside a packed bbox; LSB offset is index * COORD_W.
  localparam int BB_YBR = 0;
  localparam int BB_XBR = 1;
  localparam int BB_YTL = 2;
  localparam int BB_XTL = 3;

  function automatic int bb_lsb(input int field, input int coord_w);
    return field * coord_w;
  endfunction

  // Saturated fixed-point 1.0.
  function automatic logic [63:0] iou_one(input int frac_w);
    return (64'd1 << frac_w) - 64'd1;
  endfunction

endpackage

// File: rtl/oflow_seq_divider.sv
// Restoring divider producing (i_num << FRAC_W) / i_den, one quotient bit per
// cycle MSB first; requires i_num <= i_den so the quotient fits FRAC_W+1 bits.
module oflow_seq_divider #(
  parameter int NUM_W  = 22,
  parameter int DEN_W  = 23,
  parameter int FRAC_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [NUM_W-1:0]  i_num,
  input  logic [DEN_W-1:0]  i_den,
  output logic              o_done,
  output logic [FRAC_W:0]   o_quot
);

  localparam int CNT_W = $clog2(FRAC_W + 1);

  logic [DEN_W:0]   r_rem;
  logic [DEN_W-1:0] r_den;
  logic [FRAC_W:0]  r_quot;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic             w_ge;
  logic [DEN_W:0]   w_rem_sub;

  // Remainder stays below 2*den, so one extra bit over the divisor suffices.
  assign w_ge      = r_rem >= {1'b0, r_den};
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_den}) : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= (DEN_W + 1)'(i_num);
      r_den  <= i_den;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_quot <= {r_quot[FRAC_W-1:0], w_ge};
      r_rem  <= w_rem_sub << 1;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(FRAC_W)) r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_cnt == CNT_W'(FRAC_W));
  assign o_quot = r_quot;

endmodule

// File: rtl/oflow_calc_iou_seq.sv
// Handshaked IOU / IOU-distance calculator for one bbox pair per transaction,
// with a pass-through tag and no_overlap / degenerate flags.
module oflow_calc_iou_seq
  import oflow_calc_iou_pkg::*;
#(
  parameter int COORD_W = 11,
  parameter int FRAC_W  = 22,
  parameter int TAG_W   = 8,
  parameter int MODE    = 1
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*COORD_W-1:0] bbox_k,
  input  logic [4*COORD_W-1:0] bbox_hist,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAC_W-1:0]    iou_out,
  output logic [TAG_W-1:0]     tag_out,
  output logic                 no_overlap,
  output logic                 degenerate
);

  localparam int AW = 2 * COORD_W;
  localparam int UW = AW + 1;
  localparam logic [63:0]       ONE64 = iou_one(FRAC_W);
  localparam logic [FRAC_W-1:0] ONE   = ONE64[FRAC_W-1:0];

  function automatic logic [COORD_W-1:0] fld(input logic [4*COORD_W-1:0] b, input int f);
    return b[bb_lsb(f, COORD_W) +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] cmax(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] cmin(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Exclusive BR: an empty or inverted span on either axis gives area 0.
  function automatic logic [AW-1:0] rect_area(input logic [COORD_W-1:0] xtl, input logic [COORD_W-1:0] ytl,
                                              input logic [COORD_W-1:0] xbr, input logic [COORD_W-1:0] ybr);
    if (xbr > xtl && ybr > ytl) return AW'(xbr - xtl) * AW'(ybr - ytl);
    return '0;
  endfunction

  state_e r_state, w_next;

  logic [4*COORD_W-1:0] r_bk, r_bh;
  logic [TAG_W-1:0]     r_tag;
  logic [COORD_W-1:0]   r_xtl, r_ytl, r_xbr, r_ybr;
  logic [AW-1:0]        r_area_k, r_area_h;
  logic                 r_pend_nov, r_pend_deg;

  logic                 r_out_valid;
  logic [FRAC_W-1:0]    r_iou;
  logic [TAG_W-1:0]     r_tag_out;
  logic                 r_nov, r_deg;

  logic [AW-1:0]        w_inter;
  logic [UW-1:0]        w_union;
  logic                 w_fast;
  logic                 w_div_start, w_div_done;
  logic [FRAC_W:0]      w_quot;
  logic [FRAC_W-1:0]    w_iou_raw;

  assign w_inter = rect_area(r_xtl, r_ytl, r_xbr, r_ybr);
  assign w_union = {1'b0, r_area_k} + {1'b0, r_area_h} - {1'b0, w_inter};
  assign w_fast  = (w_union == '0) || (w_inter == '0);
  assign w_div_start = (r_state == AREA) && !w_fast;

  oflow_seq_divider #(
    .NUM_W  (AW),
    .DEN_W  (UW),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk     (clk),
    .rst     (reset_N),
    .i_start (w_div_start),
    .i_num   (w_inter),
    .i_den   (w_union),
    .o_done  (w_div_done),
    .o_quot  (w_quot)
  );

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = COORD;
      COORD:   w_next = AREA;
      AREA:    w_next = w_fast ? DONE : DIV;
      DIV:     if (w_div_done) w_next = DONE;
      DONE:    if (r_out_valid && out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Quotient bit FRAC_W only sets for inter == union (exact 1.0).
  always_comb begin
    w_iou_raw = '0;
    if (!(r_pend_nov || r_pend_deg))
      w_iou_raw = w_quot[FRAC_W] ? ONE : w_quot[FRAC_W-1:0];
  end

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      r_bk        <= '0;
      r_bh        <= '0;
      r_tag       <= '0;
      r_xtl       <= '0;
      r_ytl       <= '0;
      r_xbr       <= '0;
      r_ybr       <= '0;
      r_area_k    <= '0;
      r_area_h    <= '0;
      r_pend_nov  <= 1'b0;
      r_pend_deg  <= 1'b0;
      r_out_valid <= 1'b0;
      r_iou       <= '0;
      r_tag_out   <= '0;
      r_nov       <= 1'b0;
      r_deg       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_bk  <= bbox_k;
          r_bh  <= bbox_hist;
          r_tag <= tag_in;
        end
        COORD: begin
          r_xtl    <= cmax(fld(r_bk, BB_XTL), fld(r_bh, BB_XTL));
          r_ytl    <= cmax(fld(r_bk, BB_YTL), fld(r_bh, BB_YTL));
          r_xbr    <= cmin(fld(r_bk, BB_XBR), fld(r_bh, BB_XBR));
          r_ybr    <= cmin(fld(r_bk, BB_YBR), fld(r_bh, BB_YBR));
          r_area_k <= rect_area(fld(r_bk, BB_XTL), fld(r_bk, BB_YTL), fld(r_bk, BB_XBR), fld(r_bk, BB_YBR));
          r_area_h <= rect_area(fld(r_bh, BB_XTL), fld(r_bh, BB_YTL), fld(r_bh, BB_XBR), fld(r_bh, BB_YBR));
        end
        AREA: begin
          r_pend_deg <= (w_union == '0);
          r_pend_nov <= (w_union != '0) && (w_inter == '0);
        end
        // First DONE cycle loads the result; it then holds until the transfer.
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_iou       <= (MODE != 0) ? (ONE - w_iou_raw) : w_iou_raw;
            r_tag_out   <= r_tag;
            r_nov       <= r_pend_nov;
            r_deg       <= r_pend_deg;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE) && !reset_N;
  assign out_valid  = r_out_valid;
  assign iou_out    = r_iou;
  assign tag_out    = r_tag_out;
  assign no_overlap = r_nov;
  assign degenerate = r_deg;

endmodule

// File: tb/tb_oflow_calc_iou_seq.sv
// Directed bench: one MODE=0 and one MODE=1 instance share the same stimulus.
module tb_oflow_calc_iou_seq;

  localparam int CW = 11;
  localparam int FW = 22;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            reset_N = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [4*CW-1:0] bbox_k = '0;
  logic [4*CW-1:0] bbox_hist = '0;
  logic [TW-1:0]   tag_in = '0;

  logic          rdy0, vld0, nov0, deg0;
  logic [FW-1:0] iou0;
  logic [TW-1:0] tag0;
  logic          rdy1, vld1, nov1, deg1;
  logic [FW-1:0] iou1;
  logic [TW-1:0] tag1;

  oflow_calc_iou_seq #(.COORD_W(CW), .FRAC_W(FW), .TAG_W(TW), .MODE(0)) dut0 (
    .clk(clk), .reset_N(reset_N), .in_valid(in_valid), .in_ready(rdy0),
    .bbox_k(bbox_k), .bbox_hist(bbox_hist), .tag_in(tag_in),
    .out_valid(vld0), .out_ready(out_ready), .iou_out(iou0), .tag_out(tag0),
    .no_overlap(nov0), .degenerate(deg0));

  oflow_calc_iou_seq #(.COORD_W(CW), .FRAC_W(FW), .TAG_W(TW), .MODE(1)) dut1 (
    .clk(clk), .reset_N(reset_N), .in_valid(in_valid), .in_ready(rdy1),
    .bbox_k(bbox_k), .bbox_hist(bbox_hist), .tag_in(tag_in),
    .out_valid(vld1), .out_ready(out_ready), .iou_out(iou1), .tag_out(tag1),
    .no_overlap(nov1), .degenerate(deg1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [4*CW-1:0] bb(input int x0, input int y0, input int x1, input int y1);
    return {CW'(x0), CW'(y0), CW'(x1), CW'(y1)};
  endfunction

  typedef struct {
    logic [4*CW-1:0] k;
    logic [4*CW-1:0] h;
    logic [TW-1:0]   tag;
    int              e0;
    int              e1;
    bit              nov;
    bit              deg;
    int              lat;
    string           nm;
  } vec_t;

  vec_t vecs[8];

  // Accept one pair, measure latency from the accept edge, check both modes, transfer.
  task automatic run_pair(input vec_t v);
    int lat;
    @(negedge clk);
    chk({v.nm, ".in_ready"}, rdy0, 1);
    bbox_k = v.k; bbox_hist = v.h; tag_in = v.tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!vld0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.nm, ".latency"}, lat, v.lat);
    chk({v.nm, ".vld1"}, vld1, 1);
    chk({v.nm, ".iou_mode0"}, iou0, v.e0);
    chk({v.nm, ".iou_mode1"}, iou1, v.e1);
    chk({v.nm, ".tag"}, tag0, v.tag);
    chk({v.nm, ".no_overlap"}, nov0, v.nov);
    chk({v.nm, ".degenerate"}, deg0, v.deg);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.nm, ".valid_cleared"}, vld0, 0);
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0] = '{bb(0,0,10,10),      bb(5,0,15,10),     8'h01, 1398101, 2796202, 1'b0, 1'b0, 26, "half_overlap"};
    vecs[1] = '{bb(2,3,40,50),      bb(2,3,40,50),     8'h02, 4194303, 0,       1'b0, 1'b0, 26, "identical"};
    vecs[2] = '{bb(0,0,10,10),      bb(20,20,30,30),   8'h03, 0,       4194303, 1'b1, 1'b0, 3,  "disjoint"};
    vecs[3] = '{bb(5,5,5,9),        bb(7,7,3,9),       8'h04, 0,       4194303, 1'b0, 1'b1, 3,  "degenerate"};
    vecs[4] = '{bb(0,0,2047,2047),  bb(0,0,1,1),       8'h05, 1,       4194302, 1'b0, 1'b0, 26, "extreme_tiny"};
    vecs[5] = '{bb(0,0,4,4),        bb(2,2,6,6),       8'h06, 599186,  3595117, 1'b0, 1'b0, 26, "quarter"};
    vecs[6] = '{bb(0,0,10,10),      bb(10,0,20,10),    8'h07, 0,       4194303, 1'b1, 1'b0, 3,  "touching"};
    vecs[7] = '{bb(0,0,2047,2047),  bb(2047,2047,0,0), 8'h08, 0,       4194303, 1'b1, 1'b0, 3,  "extreme_inverted"};

    // Reset state
    #2 reset_N = 1'b1;
    #1;
    chk("reset.in_ready", rdy0, 0);
    chk("reset.out_valid", vld0, 0);
    chk("reset.iou_out", iou0, 0);
    chk("reset.tag_out", tag0, 0);
    chk("reset.flags", {nov0, deg0}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_N = 1'b0;
    @(posedge clk); #1;
    chk("release.in_ready", rdy0, 1);

    foreach (vecs[i]) run_pair(vecs[i]);

    // Backpressure: result held 10 cycles while a second pair waits upstream.
    @(negedge clk);
    bbox_k = vecs[0].k; bbox_hist = vecs[0].h; tag_in = 8'hA5; in_valid = 1'b1;
    @(posedge clk); #1;
    bbox_k = vecs[2].k; bbox_hist = vecs[2].h; tag_in = 8'h3C;
    lat = 0;
    while (!vld0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", lat, 26);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp.hold_valid", vld0, 1);
      chk("bp.hold_iou", iou0, 1398101);
      chk("bp.hold_tag", tag0, 8'hA5);
      chk("bp.hold_in_ready", rdy0, 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.transfer_valid", vld0, 0);
    chk("bp.idle_in_ready", rdy0, 1);
    @(posedge clk); #1;
    chk("bp.second_accepted", rdy0, 0);
    in_valid = 1'b0;
    lat = 0;
    while (!vld0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2.latency", lat, 3);
    chk("bp2.tag", tag0, 8'h3C);
    chk("bp2.no_overlap", nov1, 1);
    chk("bp2.iou_mode1", iou1, 4194303);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset mid-divide discards the pending result.
    @(negedge clk);
    bbox_k = vecs[0].k; bbox_hist = vecs[0].h; tag_in = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset_N = 1'b1;
    #1;
    chk("abort.out_valid", vld0, 0);
    chk("abort.in_ready", rdy0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_N = 1'b0;
    @(posedge clk); #1;
    chk("abort.idle_in_ready", rdy0, 1);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (vld0 || vld1) seen = 1'b1;
    end
    chk("abort.no_stale_result", seen, 0);
    vecs[0].tag = 8'h77;
    vecs[0].nm  = "after_abort";
    run_pair(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
